// File: rtl/mux_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter_if
// Purpose  : Requester/downstream bundle for mux_rr_arbiter. The lock vector
//            exists only when MUXARB_LOCK_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface mux_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]       req;
    logic [WIDTH-1:0] din0;
    logic [WIDTH-1:0] din1;
    logic [WIDTH-1:0] din2;
    logic [WIDTH-1:0] din3;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
`ifdef MUXARB_LOCK_EN
    logic [3:0]       lock;

    modport slave (
        input  req, din0, din1, din2, din3, out_ready, lock,
        output gnt, sel, out_valid, out_data
    );

    modport master (
        output req, din0, din1, din2, din3, out_ready, lock,
        input  gnt, sel, out_valid, out_data
    );
`else
    modport slave (
        input  req, din0, din1, din2, din3, out_ready,
        output gnt, sel, out_valid, out_data
    );

    modport master (
        output req, din0, din1, din2, din3, out_ready,
        input  gnt, sel, out_valid, out_data
    );
`endif
endinterface
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter
// Purpose  : 4-way round-robin arbiter with a one-word registered output
//            stage (IDLE/HOLD). Optional owner lock under MUXARB_LOCK_EN.
// Revision : 1.0  initial release
// ============================================================================
module mux_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mux_rr_arbiter_if.slave    bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_ptr;
    logic [1:0]       r_sel;
    logic [WIDTH-1:0] r_data;

    logic             w_any_req;
    logic             w_accept;
    logic [1:0]       w_winner;
    logic [1:0]       w_idx;
    logic             w_found;
    logic [3:0]       w_gnt;
    logic [WIDTH-1:0] w_win_data;

    assign w_any_req = |bus.req;

    // Round-robin search starts one past the last winner, so the last winner
    // has the lowest priority on the next accept.
    always_comb begin
        w_winner = r_ptr;
        w_found  = 1'b0;
        w_idx    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k + 1);
            if (!w_found && bus.req[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
`ifdef MUXARB_LOCK_EN
        if (bus.req[r_ptr] && bus.lock[r_ptr]) begin
            w_winner = r_ptr;
        end
`endif
    end

    always_comb begin
        w_win_data = bus.din0;
        case (w_winner)
            2'd0:    w_win_data = bus.din0;
            2'd1:    w_win_data = bus.din1;
            2'd2:    w_win_data = bus.din2;
            default: w_win_data = bus.din3;
        endcase
    end

    // In HOLD a new word may only be taken when the held one leaves this
    // same cycle, which gives back-to-back throughput without a bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req && !rst) begin
                    w_accept    = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready && !rst) begin
                    if (w_any_req) begin
                        w_accept    = 1'b1;
                        w_state_nxt = HOLD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_gnt = w_accept ? (4'b0001 << w_winner) : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Reset leaves ptr at 3 so requester 0 is first in line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_sel  <= 2'd0;
            r_ptr  <= 2'd3;
        end else if (w_accept) begin
            r_data <= w_win_data;
            r_sel  <= w_winner;
            r_ptr  <= w_winner;
        end
    end

    assign bus.gnt       = w_gnt;
    assign bus.sel       = r_sel;
    assign bus.out_valid = (r_state == HOLD);
    assign bus.out_data  = r_data;

endmodule
`default_nettype wire
